ex_mem_stage: RTL
=================

Name: ex_mem_stage

Overview:
- Execute-to-memory boundary stage directly downstream of the 32-bit ALU.
- Captures the ALU result and flags (cf, zf, vf, sf) plus forwarded control/data, and resolves conditional branches from the flags.
- Emits a one-cycle PC redirect for taken branches and jumps.
- Decouples EX from MEM through a valid/ready handshake backed by a two-entry skid buffer, so in_ready is a registered signal.

Parameters:
- CTRL_W, 8, width of the opaque MEM/WB control bundle, passed through unchanged.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  EX holds a valid instruction.
- in_ready  out  1  stage can accept; registered.
- alu_result  in  32  ALU result.
- cf, zf, vf, sf  in  1 each  ALU flags from a - b: carry (1 = no borrow), zero, overflow, sign.
- is_branch  in  1  conditional branch.
- is_jump  in  1  JAL/JALR.
- funct3  in  3  branch condition code.
- target_pc  in  32  branch/jump target.
- pc_plus4  in  32  link value.
- rs2_data  in  32  store data.
- rd  in  5  destination register.
- ctrl_in  in  CTRL_W  MEM/WB control.
- flush  in  1  discard all held entries.
- out_valid  out  1  MEM-side entry valid.
- out_ready  in  1  MEM accepts.
- out_result  out  32  ALU result, or pc_plus4 when is_jump.
- out_rs2_data  out  32  store data.
- out_rd  out  5  destination register.
- out_ctrl  out  CTRL_W  control bundle.
- redirect_valid  out  1  one-cycle redirect pulse.
- redirect_pc  out  32  redirect target.

Behaviour:
- Reset (sync, active-high): out_valid=0, in_ready=1, redirect_valid=0, all data outputs 0, both entries empty. Reset dominates flush and all handshakes in the same cycle.
- Accept: in_valid & in_ready at a rising edge. Fire: out_valid & out_ready.
- Storage: main entry drives the outputs; a skid entry holds one overflow item. in_ready = ~skid_full.
- On accept:
  - main empty, or main firing with skid empty → data goes to main.
  - main full and not firing → data goes to skid.
  - main firing with skid full → cannot occur, since in_ready=0.
- On fire with skid full: skid moves to main and the skid is cleared. in_ready returns to 1 in the next cycle.
- Latency: accept to out_valid is 1 cycle. Back-to-back throughput is 1 per cycle when out_ready is held high.
- Branch condition, evaluated combinationally on the incoming flags at accept:
  - 000 BEQ: zf
  - 001 BNE: ~zf
  - 100 BLT: sf^vf
  - 101 BGE: ~(sf^vf)
  - 110 BLTU: ~cf
  - 111 BGEU: cf
  - 010 and 011: not taken.
- taken = is_jump | (is_branch & cond). When is_jump, out_result = pc_plus4, regardless of is_branch.
- Redirect: redirect_valid is asserted for exactly 1 cycle, the cycle after an accept with taken=1; redirect_pc is the registered target_pc. Redirects are not gated by downstream backpressure. When redirect_valid=0, redirect_pc holds its last value.
- Flush: at the edge, both entries are cleared, out_valid=0, in_ready=1 next cycle.
  - Any same-cycle accept is dropped, with no redirect.
  - A redirect already pending from the previous cycle's accept is still emitted.
- Simultaneous accept and fire with main full and skid empty: the new data replaces main. out_valid stays 1.
- Not-taken branches and all other instructions pass through unchanged. A branch still occupies an entry (ctrl is expected to carry no write).

Decomposition:
- Shared package (defines file): funct3 branch constants (BR_BEQ … BR_BGEU) and the EX/MEM entry field widths.
- One natural sub-module: branch_cond, which is combinational (funct3 + flags → cond). It is reused by any future early-branch logic.
- The skid buffer stays inline.

Test Plan:
- Reset held 2 cycles, then released → out_valid=0, in_ready=1, redirect_valid=0, out_result=0.
- BEQ with alu_result=0x00000000, zf=1, target_pc=0x00000080, out_ready=1 → next cycle redirect_valid=1, redirect_pc=0x80, out_valid=1; pulse lasts 1 cycle.
- BLTU with cf=1, then BLT with sf=1, vf=0 → no redirect for the first; redirect for the second. funct3=010 with zf=1 → no redirect.
- JAL with pc_plus4=0x00000104, target_pc=0x00000200 → out_result=0x104, redirect_pc=0x200.
- out_ready=0, three back-to-back valid inputs with results 0x11, 0x22, 0x33 → in_ready drops after the 2nd accept and the 3rd is held. Then out_ready=1 → outputs emit 0x11, 0x22, 0x33 in order, none lost or duplicated.
- Main and skid full, flush=1 with in_valid=1 → next cycle out_valid=0, in_ready=1, no redirect for the dropped input.

Source files
------------

// File: rtl/ex_mem_stage_pkg.sv
// Shared definitions for the EX/MEM boundary: branch condition codes and
// entry field widths.
package ex_mem_stage_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;
  localparam int unsigned F3_W  = 3;

  typedef enum logic [F3_W-1:0] {
    BR_BEQ  = 3'b000,
    BR_BNE  = 3'b001,
    BR_BLT  = 3'b100,
    BR_BGE  = 3'b101,
    BR_BLTU = 3'b110,
    BR_BGEU = 3'b111
  } br_funct3_e;

endpackage

// File: rtl/ex_mem_stage_branch_cond.sv
// Resolves a conditional branch from the ALU flags of (a - b).
module branch_cond
  import ex_mem_stage_pkg::*;
(
  input  logic [F3_W-1:0] funct3,
  input  logic            cf,
  input  logic            zf,
  input  logic            vf,
  input  logic            sf,
  output logic            cond
);

  always_comb begin
    cond = 1'b0;
    case (funct3)
      BR_BEQ:  cond = zf;
      BR_BNE:  cond = ~zf;
      BR_BLT:  cond = sf ^ vf;
      BR_BGE:  cond = ~(sf ^ vf);
      BR_BLTU: cond = ~cf;
      BR_BGEU: cond = cf;
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline stage: two-entry skid buffer (main + skid), branch
// resolution and a one-cycle PC redirect pulse.
module ex_mem_stage
  import ex_mem_stage_pkg::*;
#(
  parameter int unsigned CTRL_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   alu_result,
  input  logic              cf,
  input  logic              zf,
  input  logic              vf,
  input  logic              sf,
  input  logic              is_branch,
  input  logic              is_jump,
  input  logic [F3_W-1:0]   funct3,
  input  logic [XLEN-1:0]   target_pc,
  input  logic [XLEN-1:0]   pc_plus4,
  input  logic [XLEN-1:0]   rs2_data,
  input  logic [REG_W-1:0]  rd,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_result,
  output logic [XLEN-1:0]   out_rs2_data,
  output logic [REG_W-1:0]  out_rd,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic              redirect_valid,
  output logic [XLEN-1:0]   redirect_pc
);

  typedef struct packed {
    logic [XLEN-1:0]   result;
    logic [XLEN-1:0]   rs2_data;
    logic [REG_W-1:0]  rd;
    logic [CTRL_W-1:0] ctrl;
  } entry_t;

  entry_t main_q, skid_q, in_entry;
  logic   main_valid, skid_valid;
  logic   accept, fire, cond, taken;

  branch_cond u_branch_cond (
    .funct3 (funct3),
    .cf     (cf),
    .zf     (zf),
    .vf     (vf),
    .sf     (sf),
    .cond   (cond)
  );

  always_comb begin
    taken           = is_jump | (is_branch & cond);
    in_entry.result = is_jump ? pc_plus4 : alu_result;
    in_entry.rs2_data = rs2_data;
    in_entry.rd     = rd;
    in_entry.ctrl   = ctrl_in;
    accept          = in_valid & in_ready;
    fire            = main_valid & out_ready;
  end

  // in_ready depends only on the skid flop, so EX never sees a comb path from out_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid     <= 1'b0;
      skid_valid     <= 1'b0;
      main_q         <= '0;
      skid_q         <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      redirect_valid <= accept & taken & ~flush;
      if (accept & taken & ~flush) begin
        redirect_pc <= target_pc;
      end
      if (flush) begin
        main_valid <= 1'b0;
        skid_valid <= 1'b0;
      end else if (skid_valid) begin
        if (fire) begin
          main_q     <= skid_q;
          skid_valid <= 1'b0;
        end
      end else if (accept) begin
        if (!main_valid || fire) begin
          main_q     <= in_entry;
          main_valid <= 1'b1;
        end else begin
          skid_q     <= in_entry;
          skid_valid <= 1'b1;
        end
      end else if (fire) begin
        main_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    in_ready     = ~skid_valid;
    out_valid    = main_valid;
    out_result   = main_q.result;
    out_rs2_data = main_q.rs2_data;
    out_rd       = main_q.rd;
    out_ctrl     = main_q.ctrl;
  end

endmodule
